// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// multicycle_ctrl_pkg - shared state, opcode/funct and datapath control codes
// Rev 1.0
//==============================================================================
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        IC_NOP  = 4'd0,
        IC_ADDU = 4'd1,
        IC_SUBU = 4'd2,
        IC_ORI  = 4'd3,
        IC_LUI  = 4'd4,
        IC_LW   = 4'd5,
        IC_SW   = 4'd6,
        IC_BEQ  = 4'd7,
        IC_J    = 4'd8,
        IC_JAL  = 4'd9,
        IC_JR   = 4'd10
    } iclass_t;

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_JAL   = 6'h03;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_ORI   = 6'h0D;
    localparam logic [5:0] C_OP_LUI   = 6'h0F;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;

    localparam logic [5:0] C_FN_JR    = 6'h08;
    localparam logic [5:0] C_FN_ADDU  = 6'h21;
    localparam logic [5:0] C_FN_SUBU  = 6'h23;

    localparam logic [1:0] C_NPC_PC4    = 2'd0;
    localparam logic [1:0] C_NPC_BRANCH = 2'd1;
    localparam logic [1:0] C_NPC_JUMP   = 2'd2;
    localparam logic [1:0] C_NPC_GPR    = 2'd3;

    localparam logic [2:0] C_EXT_SIGN = 3'd0;
    localparam logic [2:0] C_EXT_ZERO = 3'd1;
    localparam logic [2:0] C_EXT_LUI  = 3'd2;

    localparam logic [1:0] C_ALU_ADD   = 2'd0;
    localparam logic [1:0] C_ALU_SUB   = 2'd1;
    localparam logic [1:0] C_ALU_OR    = 2'd2;
    localparam logic [1:0] C_ALU_PASSB = 2'd3;

    localparam logic [1:0] C_DST_RT = 2'd0;
    localparam logic [1:0] C_DST_RD = 2'd1;
    localparam logic [1:0] C_DST_RA = 2'd2;

    localparam logic [1:0] C_WD_ALU = 2'd0;
    localparam logic [1:0] C_WD_MEM = 2'd1;
    localparam logic [1:0] C_WD_PC4 = 2'd2;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_dec.sv
`default_nettype none
//==============================================================================
// multicycle_ctrl_dec - combinational opcode/funct to instruction-class decoder
// Rev 1.0
//==============================================================================
module multicycle_ctrl_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output iclass_t    o_iclass
);

    // Anything not recognised falls through as a NOP.
    always_comb begin
        o_iclass = IC_NOP;
        case (i_opcode)
            C_OP_RTYPE: begin
                case (i_funct)
                    C_FN_ADDU: o_iclass = IC_ADDU;
                    C_FN_SUBU: o_iclass = IC_SUBU;
                    C_FN_JR:   o_iclass = IC_JR;
                    default:   o_iclass = IC_NOP;
                endcase
            end
            C_OP_J:   o_iclass = IC_J;
            C_OP_JAL: o_iclass = IC_JAL;
            C_OP_BEQ: o_iclass = IC_BEQ;
            C_OP_ORI: o_iclass = IC_ORI;
            C_OP_LUI: o_iclass = IC_LUI;
            C_OP_LW:  o_iclass = IC_LW;
            C_OP_SW:  o_iclass = IC_SW;
            default:  o_iclass = IC_NOP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
//==============================================================================
// multicycle_ctrl - five-state multicycle MIPS-subset control FSM
// Rev 1.0
//==============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic [1:0] npc_sel,
    output logic [2:0] ext_op,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       mem_we,
    output logic       mem_re,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       instr_done
);

    state_t  r_state;
    state_t  w_next;
    iclass_t w_iclass;

    multicycle_ctrl_dec u_dec (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_iclass (w_iclass)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        npc_sel    = C_NPC_PC4;
        ext_op     = C_EXT_SIGN;
        alu_src    = 1'b0;
        alu_op     = C_ALU_ADD;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = C_DST_RT;
        wd_sel     = C_WD_ALU;
        instr_done = 1'b0;
        case (r_state)
            ST_FETCH: begin
                ir_we  = 1'b1;
                pc_we  = 1'b1;
                w_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_iclass)
                    IC_J: begin
                        pc_we      = 1'b1;
                        npc_sel    = C_NPC_JUMP;
                        instr_done = 1'b1;
                        w_next     = ST_FETCH;
                    end
                    IC_JAL: begin
                        pc_we   = 1'b1;
                        npc_sel = C_NPC_JUMP;
                        w_next  = ST_WB;
                    end
                    IC_NOP: begin
                        instr_done = 1'b1;
                        w_next     = ST_FETCH;
                    end
                    default: w_next = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                w_next = ST_WB;
                case (w_iclass)
                    IC_SUBU: alu_op = C_ALU_SUB;
                    IC_ORI: begin
                        ext_op  = C_EXT_ZERO;
                        alu_src = 1'b1;
                        alu_op  = C_ALU_OR;
                    end
                    IC_LUI: begin
                        ext_op  = C_EXT_LUI;
                        alu_src = 1'b1;
                        alu_op  = C_ALU_PASSB;
                    end
                    IC_LW, IC_SW: begin
                        alu_src = 1'b1;
                        w_next  = ST_MEM;
                    end
                    IC_BEQ: begin
                        alu_op     = C_ALU_SUB;
                        pc_we      = zero;
                        npc_sel    = C_NPC_BRANCH;
                        instr_done = 1'b1;
                        w_next     = ST_FETCH;
                    end
                    IC_JR: begin
                        pc_we      = 1'b1;
                        npc_sel    = C_NPC_GPR;
                        instr_done = 1'b1;
                        w_next     = ST_FETCH;
                    end
                    default: alu_op = C_ALU_ADD;
                endcase
            end
            ST_MEM: begin
                mem_re = (w_iclass == IC_LW);
                mem_we = (w_iclass == IC_SW);
                if (mem_ready) begin
                    instr_done = (w_iclass == IC_SW);
                    w_next     = (w_iclass == IC_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                w_next     = ST_FETCH;
                case (w_iclass)
                    IC_ADDU, IC_SUBU: reg_dst = C_DST_RD;
                    IC_LW:            wd_sel  = C_WD_MEM;
                    IC_JAL: begin
                        reg_dst = C_DST_RA;
                        wd_sel  = C_WD_PC4;
                    end
                    default:          reg_dst = C_DST_RT;
                endcase
            end
            default: w_next = ST_FETCH;
        endcase
        // Reset masks every strobe at once, so an aborted access stops mid-cycle.
        if (!reset) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            npc_sel    = C_NPC_PC4;
            ext_op     = C_EXT_SIGN;
            alu_src    = 1'b0;
            alu_op     = C_ALU_ADD;
            mem_we     = 1'b0;
            mem_re     = 1'b0;
            reg_we     = 1'b0;
            reg_dst    = C_DST_RT;
            wd_sel     = C_WD_ALU;
            instr_done = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
//==============================================================================
// tb_multicycle_ctrl - randomized self-checking bench with per-cycle reference model
// Rev 1.0
//==============================================================================
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic [1:0] npc_sel;
        logic [2:0] ext_op;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_we;
        logic       mem_re;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       done;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, alu_src, mem_we, mem_re, reg_we, instr_done;
    logic [1:0] npc_sel, alu_op, reg_dst, wd_sel;
    logic [2:0] ext_op;
    outs_t      act;

    int n_checks = 0;
    int n_fail   = 0;

    outs_t exp_q[$];
    bit    rdy_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .npc_sel    (npc_sel),
        .ext_op     (ext_op),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .wd_sel     (wd_sel),
        .instr_done (instr_done)
    );

    assign act = {pc_we, ir_we, npc_sel, ext_op, alu_src, alu_op,
                  mem_we, mem_re, reg_we, reg_dst, wd_sel, instr_done};

    task automatic push(input outs_t o, input bit rdy);
        exp_q.push_back(o);
        rdy_q.push_back(rdy);
    endtask

    // Reference: expected outputs for every cycle of one instruction, built from its rules.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input int waits);
        bit    addu, subu, jr, ori, lui, lw, sw, beq, j, jal, known;
        outs_t o;
        addu  = (op == 6'h00) && (fn == 6'h21);
        subu  = (op == 6'h00) && (fn == 6'h23);
        jr    = (op == 6'h00) && (fn == 6'h08);
        j     = (op == 6'h02);
        jal   = (op == 6'h03);
        beq   = (op == 6'h04);
        ori   = (op == 6'h0D);
        lui   = (op == 6'h0F);
        lw    = (op == 6'h23);
        sw    = (op == 6'h2B);
        known = addu | subu | jr | j | jal | beq | ori | lui | lw | sw;
        exp_q.delete();
        rdy_q.delete();
        o = '0; o.ir_we = 1'b1; o.pc_we = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
        o = '0;
        if (!known) begin
            o.done = 1'b1;
            push(o, 1'($urandom_range(0, 1)));
            return;
        end
        if (j || jal) begin
            o.pc_we = 1'b1; o.npc_sel = 2'd2; o.done = j;
            push(o, 1'($urandom_range(0, 1)));
            if (j) return;
            o = '0; o.reg_we = 1'b1; o.reg_dst = 2'd2; o.wd_sel = 2'd2; o.done = 1'b1;
            push(o, 1'($urandom_range(0, 1)));
            return;
        end
        push(o, 1'($urandom_range(0, 1)));
        o = '0;
        o.ext_op  = ori ? 3'd1 : (lui ? 3'd2 : 3'd0);
        o.alu_src = ori | lui | lw | sw;
        o.alu_op  = (subu || beq) ? 2'd1 : (ori ? 2'd2 : (lui ? 2'd3 : 2'd0));
        if (beq) begin o.pc_we = z;    o.npc_sel = 2'd1; o.done = 1'b1; end
        if (jr)  begin o.pc_we = 1'b1; o.npc_sel = 2'd3; o.done = 1'b1; end
        push(o, 1'($urandom_range(0, 1)));
        if (beq || jr) return;
        if (lw || sw) begin
            for (int i = 0; i <= waits; i++) begin
                o = '0; o.mem_re = lw; o.mem_we = sw; o.done = sw && (i == waits);
                push(o, i == waits);
            end
            if (sw) return;
        end
        o = '0; o.reg_we = 1'b1; o.done = 1'b1;
        o.reg_dst = (addu || subu) ? 2'd1 : 2'd0;
        o.wd_sel  = lw ? 2'd1 : 2'd0;
        push(o, 1'($urandom_range(0, 1)));
    endtask

    // Runs up to max_cyc cycles of the instruction (all of them when max_cyc < 0).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int waits, input string name, input int max_cyc);
        build(op, fn, z, waits);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (max_cyc >= 0 && i >= max_cyc) break;
            @(negedge clk);
            opcode    = op;
            funct     = fn;
            zero      = z;
            mem_ready = rdy_q[i];
            #1;
            n_checks++;
            if (act !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s op=%h fn=%h cycle %0d: got %h expected %h",
                         name, op, fn, i, act, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        opcode = 6'h23;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (act !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %h expected 0", i, act);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_ori();
        run_instr(6'h0D, 6'($urandom), 1'($urandom), 0, "ori", -1);
    endtask

    task automatic test_lw_wait();
        run_instr(6'h23, 6'($urandom), 1'($urandom), 3, "lw_wait3", -1);
    endtask

    task automatic test_beq();
        run_instr(6'h04, 6'($urandom), 1'b1, 0, "beq_taken", -1);
        run_instr(6'h04, 6'($urandom), 1'b0, 0, "beq_not_taken", -1);
    endtask

    task automatic test_jal();
        run_instr(6'h03, 6'($urandom), 1'($urandom), 0, "jal", -1);
        run_instr(6'h02, 6'($urandom), 1'($urandom), 0, "j", -1);
        run_instr(6'h00, 6'h08, 1'($urandom), 0, "jr", -1);
    endtask

    task automatic test_nop();
        run_instr(6'h3F, 6'($urandom), 1'($urandom), 0, "nop_3f", -1);
        run_instr(6'h00, 6'h3F, 1'($urandom), 0, "nop_rtype", -1);
    endtask

    task automatic test_sw_abort();
        run_instr(6'h2B, 6'h00, 1'b0, 5, "sw_pre_abort", 4);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL sw_abort_async: got %h expected 0", act);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL sw_abort_held: got %h expected 0", act);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        run_instr(6'h2B, 6'h00, 1'b0, 0, "sw_after_abort", -1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h0D, 6'h0F, 6'h23, 6'h2B};
        logic [5:0] fns[3]  = '{6'h21, 6'h23, 6'h08};
        logic [5:0] op, fn;
        int         k;
        for (int n = 0; n < 150; n++) begin
            k  = int'($urandom_range(0, 11));
            fn = 6'($urandom);
            if (k < 10) op = ops[k];
            else if (k == 10) op = 6'($urandom);
            else op = 6'h00;
            if (k < 3) fn = fns[k];
            run_instr(op, fn, 1'($urandom), int'($urandom_range(0, 3)), "random", -1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ori();
        test_lw_wait();
        test_beq();
        test_jal();
        test_nop();
        test_sw_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port opcode, input, 6, instr[31:26] from the external IR, stable from DECODE until the next FETCH.
REQ-004 SHALL have port funct, input, 6, instr[5:0] from the external IR.
REQ-005 SHALL have port zero, input, 1, ALU equal flag, sampled in EXEC.
REQ-006 SHALL have port mem_ready, input, 1, data-memory acknowledge, sampled in MEM.
REQ-007 SHALL have port pc_we, output, 1, PC write enable.
REQ-008 SHALL have port ir_we, output, 1, IR write enable.
REQ-009 SHALL have port npc_sel, output, 2, PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = GPR[rs].
REQ-010 SHALL have port ext_op, output, 3, immediate-extender mode: 0 = sign, 1 = zero, 2 = load-upper; 3-7 unused.
REQ-011 SHALL have port alu_src, output, 1, ALU operand B: 0 = GPR[rt], 1 = extended immediate.
REQ-012 SHALL have port alu_op, output, 2, ALU operation: 0 = add, 1 = sub, 2 = or, 3 = pass B.
REQ-013 SHALL have port mem_we, output, 1, data-memory write strobe.
REQ-014 SHALL have port mem_re, output, 1, data-memory read request.
REQ-015 SHALL have port reg_we, output, 1, GPR write enable.
REQ-016 SHALL have port reg_dst, output, 2, GPR write address: 0 = rt, 1 = rd, 2 = $31.
REQ-017 SHALL have port wd_sel, output, 2, GPR write data: 0 = ALU, 1 = memory, 2 = PC+4.
REQ-018 SHALL have port instr_done, output, 1, one-cycle pulse in the last cycle of each instruction.

Function
REQ-019 SHALL implement the states FETCH, DECODE, EXEC, MEM and WB, with registered state and outputs decoded combinationally from the state, opcode and funct.
REQ-020 FETCH SHALL assert ir_we=1, pc_we=1 and npc_sel=0, then go to DECODE.
REQ-021 DECODE SHALL go to EXEC for addu, subu, ori, lui, lw, sw, beq and jr; for j and jal it SHALL assert pc_we=1 with npc_sel=2, and jal SHALL go to WB while j goes to FETCH.
REQ-022 Unsupported opcode/funct SHALL be a NOP: no write enables in DECODE, instr_done=1, next state FETCH.
REQ-023 In EXEC, ext_op SHALL be 0 for lw, sw and beq, 1 for ori and 2 for lui; alu_src SHALL be 1 for ori, lui, lw and sw.
REQ-024 In EXEC, alu_op SHALL be 0 for addu/lw/sw, 1 for subu/beq, 2 for ori and 3 for lui.
REQ-025 In EXEC, beq SHALL assert pc_we=zero with npc_sel=1, set instr_done=1 and return to FETCH.
REQ-026 In EXEC, jr SHALL assert pc_we=1 with npc_sel=3, set instr_done=1 and return to FETCH.
REQ-027 In EXEC, lw and sw SHALL go to MEM, and all other instructions SHALL go to WB.
REQ-028 MEM SHALL hold mem_re=1 (lw) or mem_we=1 (sw) every cycle until mem_ready=1, and SHALL stay in MEM while mem_ready=0.
REQ-029 When MEM sees mem_ready=1, lw SHALL go to WB; sw SHALL set instr_done=1 and go to FETCH.
REQ-030 WB SHALL assert reg_we=1 and instr_done=1, then go to FETCH.
REQ-031 In WB, reg_dst/wd_sel SHALL be 1/0 for addu and subu, 0/0 for ori and lui, 0/1 for lw, and 2/2 for jal.
REQ-032 Latency with mem_ready tied high SHALL be: j = 2, beq/jr = 3, jal = 3, R-type/ori/lui/sw = 4, lw = 5 cycles.
REQ-033 Every output not named for the current state SHALL be 0.

Reset
REQ-034 While reset=0, state SHALL be FETCH and all outputs SHALL be 0, including ir_we and pc_we.
REQ-035 Reset asserted mid-instruction SHALL abort it immediately, with no further write strobes.
REQ-036 The first rising clk after reset deasserts SHALL execute FETCH.

Structure
REQ-037 A shared package SHALL hold the state encoding, the opcode/funct constants and the ext_op/alu_op/npc_sel/reg_dst/wd_sel codes, so that the extender and ALU decode the same values.
REQ-038 The design SHALL have one sub-module, multicycle_ctrl_dec, a combinational opcode/funct-to-instruction-class decoder; the FSM SHALL stay in the top.

Verification
REQ-039 Release reset, then ori (opcode 0x0D) with mem_ready=1 -> states FETCH, DECODE, EXEC (ext_op=1, alu_src=1, alu_op=2), WB (reg_we=1, reg_dst=0); instr_done in cycle 4.
REQ-040 lw (0x23) with mem_ready low for 3 MEM cycles -> mem_re=1 for 4 cycles, then WB with wd_sel=1; total 8 cycles.
REQ-041 beq (0x04) -> with zero=1, pc_we=1 and npc_sel=1 in EXEC; with zero=0, pc_we=0; both return to FETCH after 3 cycles.
REQ-042 jal (0x03) -> DECODE: pc_we=1, npc_sel=2; WB: reg_dst=2, wd_sel=2, reg_we=1; 3 cycles total.
REQ-043 sw (0x2B) with reset pulled low during MEM -> mem_we drops to 0 asynchronously; FETCH follows the reset release.
REQ-044 opcode 0x3F -> NOP, with instr_done in DECODE and no write enables.
